store_sequencer: RTL and testbench

- Multi-cycle control-unit state machine that consumes the instruction encoder's 10-bit state number and drives the datapath strobes.
- Owns fetch, decode and the byte-store (immediate and register offset) sequences: offset, pre-indexed and post-indexed, each in add or subtract form.
- Sits between the encoder/condition tester and the datapath/memory interface.
- Unsupported encodings retire as NOPs.

---
 rtl/control_unit_pkg.sv | 24 ++
 rtl/moc_timeout_counter.sv | 18 +
 rtl/store_sequencer.sv | 78 +++++++
 tb/tb_store_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: state numbers, ALU/select encodings and store-entry classification shared by encoder and sequencer.
package control_unit_pkg;
  localparam logic [9:0] S_RESET = 10'd0, S_FETCH0 = 10'd1, S_FETCH1 = 10'd2, S_FETCH2 = 10'd3;
  localparam logic [9:0] S_DECODE = 10'd4, S_TRAP = 10'd1023;
  localparam logic [9:0] E_IMM_OFS_ADD = 10'd20, E_REG_OFS_ADD = 10'd21, E_IMM_PRE_ADD = 10'd22;
  localparam logic [9:0] E_REG_PRE_ADD = 10'd23, E_IMM_POST_ADD = 10'd24, E_REG_POST_ADD = 10'd27;
  localparam logic [9:0] E_IMM_OFS_SUB = 10'd30, E_REG_OFS_SUB = 10'd31, E_IMM_PRE_SUB = 10'd32;
  localparam logic [9:0] E_REG_PRE_SUB = 10'd33, E_IMM_POST_SUB = 10'd34, E_REG_POST_SUB = 10'd37;
  localparam logic [9:0] OFS_MDR = 10'd100, OFS_MEM = 10'd200, OFS_WB = 10'd300;
  localparam logic [3:0] ALU_NONE = 4'b0000, ALU_ADD = 4'b0100, ALU_SUB = 4'b0010;
  localparam logic A_RN = 1'b0, A_PC = 1'b1;
  localparam logic [1:0] B_IMM = 2'b00, B_RM = 2'b01, B_FOUR = 2'b10;
  localparam logic MAR_ALU = 1'b0, MAR_RN = 1'b1;
  localparam logic DST_RN = 1'b1;
  typedef enum logic [1:0] {K_NONE, K_OFS, K_PRE, K_POST} kind_t;
  function automatic kind_t entry_kind(input logic [9:0] s);
    case (s)
      E_IMM_OFS_ADD, E_REG_OFS_ADD, E_IMM_OFS_SUB, E_REG_OFS_SUB:     return K_OFS;
      E_IMM_PRE_ADD, E_REG_PRE_ADD, E_IMM_PRE_SUB, E_REG_PRE_SUB:     return K_PRE;
      E_IMM_POST_ADD, E_REG_POST_ADD, E_IMM_POST_SUB, E_REG_POST_SUB: return K_POST;
      default:                                                        return K_NONE;
    endcase
  endfunction
endpackage

// File: rtl/moc_timeout_counter.sv
// moc_timeout_counter: counts consecutive memory-wait cycles and flags when the limit is reached.
module moc_timeout_counter #(
  parameter int MAX = 15,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + W'(1);
  end
  assign expired = cnt_q == W'(MAX);
endmodule

// File: rtl/store_sequencer.sv
// store_sequencer: Moore control FSM for fetch, decode and byte-store sequences, with moc timeout trap.
module store_sequencer
  import control_unit_pkg::*;
#(
  parameter int MOC_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] encoded_state,
  input  logic       cond_pass,
  input  logic       moc,
  output logic [9:0] state,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       mar_ld,
  output logic       mdr_ld,
  output logic       rf_ld,
  output logic       tmp_ld,
  output logic       mem_en,
  output logic       mem_rw,
  output logic       mem_byte,
  output logic [3:0] alu_op,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       mar_sel,
  output logic       rf_dst_sel,
  output logic       bus_err
);
  logic [9:0] state_q, state_d;
  kind_t k_ent, k_mdr, k_mem, k_wb;
  logic wb_st, wait_st, cnt_en, expired;
  // Each store phase is its entry code plus a fixed offset, so classify by subtracting back.
  assign k_ent   = entry_kind(state_q);
  assign k_mdr   = entry_kind(state_q - OFS_MDR);
  assign k_mem   = entry_kind(state_q - OFS_MEM);
  assign k_wb    = entry_kind(state_q - OFS_WB);
  assign wb_st   = k_wb == K_PRE || k_wb == K_POST;
  assign wait_st = state_q == S_FETCH2 || k_mem != K_NONE;
  assign cnt_en  = wait_st && !moc;
  moc_timeout_counter #(.MAX(MOC_TIMEOUT), .W(CNT_W)) u_timeout (
    .clk(clk), .reset_n(reset_n), .en(cnt_en), .clr(!cnt_en), .expired(expired)
  );
  always_comb begin
    state_d = state_q == S_RESET  ? S_FETCH0 :
              state_q == S_FETCH0 ? S_FETCH1 :
              state_q == S_FETCH1 ? S_FETCH2 :
              state_q == S_DECODE ? (cond_pass && entry_kind(encoded_state) != K_NONE ? encoded_state : S_FETCH0) :
              state_q == S_TRAP   ? S_TRAP :
              k_ent != K_NONE || k_mdr != K_NONE ? state_q + OFS_MDR :
              wait_st ? (moc ? (state_q == S_FETCH2 ? S_DECODE : k_mem == K_OFS ? S_FETCH0 : state_q + OFS_MDR)
                             : (expired ? S_TRAP : state_q)) :
              wb_st ? S_FETCH0 : S_RESET;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_RESET;
    else state_q <= state_d;
  end
  assign state      = state_q;
  assign pc_ld      = state_q == S_FETCH1;
  assign ir_ld      = state_q == S_FETCH2 && moc;
  assign mar_ld     = state_q == S_FETCH0 || k_ent != K_NONE;
  assign mdr_ld     = k_mdr != K_NONE;
  assign rf_ld      = wb_st;
  assign rf_dst_sel = wb_st ? DST_RN : 1'b0;
  assign tmp_ld     = k_ent == K_PRE || k_ent == K_POST;
  assign mem_en     = state_q == S_FETCH1 || state_q == S_FETCH2 || k_mem != K_NONE;
  assign mem_rw     = state_q == S_FETCH1 || state_q == S_FETCH2;
  assign mem_byte   = k_mem != K_NONE;
  assign alu_op     = state_q == S_FETCH1 ? ALU_ADD :
                      k_ent != K_NONE ? (state_q >= E_IMM_OFS_SUB ? ALU_SUB : ALU_ADD) : ALU_NONE;
  // Fetch reads the PC into MAR with both selects raised; entry states always use Rn.
  assign alu_a_sel  = state_q == S_FETCH0 || state_q == S_FETCH1 ? A_PC : A_RN;
  assign alu_b_sel  = state_q == S_FETCH1 ? B_FOUR :
                      k_ent != K_NONE ? (state_q[0] ? B_RM : B_IMM) : 2'b00;
  assign mar_sel    = state_q == S_FETCH0 || k_ent == K_POST ? MAR_RN : MAR_ALU;
  assign bus_err    = state_q == S_TRAP;
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed stimulus with an arithmetic reference model compared every cycle.
module tb_store_sequencer;
  localparam int TO = 15;
  logic clk = 0, reset_n, cond_pass, moc;
  logic [9:0] encoded_state, state;
  logic pc_ld, ir_ld, mar_ld, mdr_ld, rf_ld, tmp_ld, mem_en, mem_rw, mem_byte;
  logic [3:0] alu_op;
  logic alu_a_sel, mar_sel, rf_dst_sel, bus_err;
  logic [1:0] alu_b_sel;
  typedef struct packed {
    logic pc, ir, mar, mdr, rf, tmp, en, rw, by;
    logic [3:0] op;
    logic a;
    logic [1:0] b;
    logic ms, dst, err;
  } outs_t;
  outs_t dut_o;
  int checks = 0, errors = 0, m_s = 0, m_c = 0, ir_cnt = 0, rf_cnt = 0, n;
  int trace[$], exp_q[$];
  bit go = 0;

  store_sequencer #(.MOC_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .encoded_state(encoded_state), .cond_pass(cond_pass), .moc(moc),
    .state(state), .pc_ld(pc_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .rf_ld(rf_ld),
    .tmp_ld(tmp_ld), .mem_en(mem_en), .mem_rw(mem_rw), .mem_byte(mem_byte), .alu_op(alu_op),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .mar_sel(mar_sel), .rf_dst_sel(rf_dst_sel), .bus_err(bus_err)
  );
  assign dut_o = {pc_ld, ir_ld, mar_ld, mdr_ld, rf_ld, tmp_ld, mem_en, mem_rw, mem_byte,
                  alu_op, alu_a_sel, alu_b_sel, mar_sel, rf_dst_sel, bus_err};

  always #5 clk = ~clk;

  function automatic bit legal(int v);
    int d = v % 10;
    return v >= 20 && v <= 37 && (d <= 4 || d == 7);
  endfunction
  function automatic bit in_store(int s, int ph);
    return s / 100 == ph && legal(s % 100);
  endfunction
  function automatic bit m_wait(int s);
    return s == 3 || in_store(s, 2);
  endfunction
  function automatic int m_next(int s, int c, int enc, bit cp, bit mc);
    int d = (s % 100) % 10;
    if (s == 0) return 1;
    if (s == 1) return 2;
    if (s == 2) return 3;
    if (s == 3) return mc ? 4 : (c == TO ? 1023 : 3);
    if (s == 4) return (cp && legal(enc)) ? enc : 1;
    if (s == 1023) return 1023;
    if (in_store(s, 0) || in_store(s, 1)) return s + 100;
    if (in_store(s, 2)) return mc ? (d < 2 ? 1 : s + 100) : (c == TO ? 1023 : s);
    if (in_store(s, 3) && d >= 2) return 1;
    return 0;
  endfunction
  function automatic outs_t m_out(int s, bit mc);
    outs_t o;
    int b = s % 100, d = b % 10;
    o = '0;
    if (s == 1) begin o.mar = 1; o.ms = 1; o.a = 1; end
    if (s == 2) begin o.en = 1; o.rw = 1; o.a = 1; o.b = 2'b10; o.op = 4'b0100; o.pc = 1; end
    if (s == 3) begin o.en = 1; o.rw = 1; o.ir = mc; end
    if (s == 1023) o.err = 1;
    if (in_store(s, 0)) begin
      o.op = b >= 30 ? 4'b0010 : 4'b0100;
      o.b = (d % 2 == 0) ? 2'b00 : 2'b01;
      o.mar = 1; o.ms = d >= 4; o.tmp = d >= 2;
    end
    if (in_store(s, 1)) o.mdr = 1;
    if (in_store(s, 2)) begin o.en = 1; o.by = 1; end
    if (in_store(s, 3) && d >= 2) begin o.rf = 1; o.dst = 1; end
    return o;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin m_s <= 0; m_c <= 0; end
    else begin
      m_s <= m_next(m_s, m_c, int'(encoded_state), cond_pass, moc);
      m_c <= (m_wait(m_s) && !moc) ? m_c + 1 : 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (go) begin
    chk("model_state", 32'(state), 32'(m_s));
    chk("model_outs", 32'(dut_o), 32'(m_out(m_s, moc)));
    ir_cnt += int'(ir_ld);
    rf_cnt += int'(rf_ld);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic tick_rec();
    tick();
    trace.push_back(int'(state));
  endtask
  task automatic chk_trace(input string nm);
    chk({nm, "_len"}, 32'(trace.size()), 32'(exp_q.size()));
    for (int i = 0; i < trace.size() && i < exp_q.size(); i++) chk(nm, 32'(trace[i]), 32'(exp_q[i]));
  endtask
  task automatic wait_state(input logic [9:0] s, input int budget);
    int k = 0;
    while (state !== s && k < budget) begin tick(); k++; end
    chk("reach_state", 32'(state), 32'(s));
  endtask
  task automatic to_decode();
    moc = 1;
    wait_state(10'd4, 12);
  endtask

  initial begin
    reset_n = 0; moc = 0; cond_pass = 0; encoded_state = 0;
    tick(); tick();
    go = 1;
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    reset_n = 1;
    tick();
    chk("boot_state", 32'(state), 1);
    chk("model_boot", 32'(m_s), 1);
    ir_cnt = 0; trace = {int'(state)};
    tick_rec(); chk("fetch_pc_ld", 32'(pc_ld), 1);
    tick_rec(); tick_rec(); moc = 1; tick_rec(); moc = 0;
    chk("fetch_ir_once", 32'(ir_cnt), 1);
    exp_q = {1, 2, 3, 3, 4}; chk_trace("fetch_seq");
    cond_pass = 1; encoded_state = 10'd20; moc = 1; rf_cnt = 0; trace = {int'(state)};
    tick_rec(); chk("ofs_alu_op", 32'(alu_op), 32'(4'b0100)); chk("ofs_b_sel", 32'(alu_b_sel), 0);
    tick_rec(); tick_rec(); tick_rec();
    exp_q = {4, 20, 120, 220, 1}; chk_trace("ofs_seq");
    chk("ofs_no_rf", 32'(rf_cnt), 0);
    to_decode();
    encoded_state = 10'd37; moc = 0; trace = {int'(state)};
    tick_rec();
    chk("post_mar_sel", 32'(mar_sel), 1); chk("post_tmp_ld", 32'(tmp_ld), 1);
    chk("post_alu_op", 32'(alu_op), 32'(4'b0010)); chk("post_b_sel", 32'(alu_b_sel), 1);
    tick_rec(); tick_rec(); moc = 1; tick_rec(); chk("post_rf_ld", 32'(rf_ld), 1);
    tick_rec();
    exp_q = {4, 37, 137, 237, 337, 1}; chk_trace("post_seq");
    to_decode();
    cond_pass = 0; encoded_state = 10'd22; trace = {int'(state)}; tick_rec();
    exp_q = {4, 1}; chk_trace("nop_cond");
    to_decode();
    cond_pass = 1; encoded_state = 10'd25; trace = {int'(state)}; tick_rec();
    exp_q = {4, 1}; chk_trace("nop_enc");
    to_decode();
    encoded_state = 10'd20; moc = 0;
    tick(); tick(); tick();
    chk("to_in_220", 32'(state), 220);
    n = 0;
    while (state == 10'd220 && n < 40) begin tick(); n++; end
    chk("to_cycles", 32'(n), 16);
    chk("to_trap", 32'(state), 1023);
    chk("to_bus_err", 32'(bus_err), 1);
    moc = 1; tick(); tick(); tick();
    chk("trap_hold", 32'(state), 1023);
    reset_n = 0; tick(); reset_n = 1;
    to_decode();
    encoded_state = 10'd20; moc = 0;
    tick(); tick(); tick();
    repeat (15) tick();
    chk("edge_hold", 32'(state), 220);
    moc = 1; tick();
    chk("edge_done", 32'(state), 1);
    chk("edge_no_err", 32'(bus_err), 0);
    to_decode();
    encoded_state = 10'd22; moc = 0;
    tick(); tick(); tick();
    chk("pend_write", 32'(state), 222);
    reset_n = 0; tick(); tick();
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    reset_n = 1; tick();
    chk("mid_rst_boot", 32'(state), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
